line_stepper: RTL and testbench
===============================

Name: line_stepper

Overview:
- Responder side of the strobe/ready point interface used by the vectorfpga top level.
- Accepts a target endpoint, then walks the beam from its current position to that endpoint using integer Bresenham stepping.
- Emits one DAC coordinate pair per clock while drawing.
- Sits between the point/display-list producer and the X/Y DAC drivers.

Parameters:
- WIDTH, 12, coordinate width in bits (unsigned).
- X_INIT, 0, beam X position after reset.
- Y_INIT, 0, beam Y position after reset.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-low reset.
- strobe  input  1  producer asserts for one cycle to hand over a target; only sampled while ready=1.
- ready  output  1  high when idle and able to accept a target.
- x  input  WIDTH  target X, sampled with strobe.
- y  input  WIDTH  target Y, sampled with strobe.
- x_out  output  WIDTH  current beam X.
- y_out  output  WIDTH  current beam Y.
- out_valid  output  1  x_out/y_out is a drawn point this cycle.
- done  output  1  one-cycle pulse when the final point is emitted.

Behaviour:
- Reset (reset=0 at clk edge):
  - state=IDLE, ready=1, out_valid=0, done=0.
  - x_out=X_INIT, y_out=Y_INIT.
  - err and step registers cleared.
  - Applies from any state; a line in progress is abandoned with no done pulse.
- States: IDLE, SETUP, DRAW.
- IDLE:
  - ready=1.
  - strobe=1 at edge T latches x,y into tx,ty and moves to SETUP; ready=0 from T+1.
  - strobe while ready=0 is ignored; no queueing.
- SETUP (1 cycle), computed with signed WIDTH+2-bit arithmetic:
  - dx=|tx-x_out|, dy=-|ty-y_out|.
  - sx=+1 if tx>x_out, else -1; sy likewise.
  - err=dx+dy.
  - Next state DRAW.
- DRAW, every cycle:
  - out_valid=1 with the current x_out/y_out; the first DRAW cycle emits the start point.
  - If x_out==tx and y_out==ty: done=1 this cycle, next state IDLE, ready=1 next cycle.
  - Else, with e2=2*err:
    - If e2>=dy: err+=dy, x_out+=sx.
    - If e2<=dx: err+=dx, y_out+=sy.
    - Both updates apply in the same cycle when both hold (diagonal step).
- Latency: strobe at edge T → first out_valid at cycle T+2.
- Point count: max(|dx|,|dy|)+1 valid cycles, last one carrying done.
- Every step moves each axis by at most 1; coordinates never leave the bounding box of start and target, so no wrap-around.
- Zero-length line (target == current): one valid cycle with done=1.
- x_out/y_out hold their value in IDLE and SETUP; the endpoint becomes the start of the next line.
- Full range 0..2^WIDTH-1 on either axis is supported without overflow (err range ±2^(WIDTH+1)).

Optional Feature:
- Macro: LINE_STEPPER_BLANK_MOVE_EN.
- Defined:
  - Adds input blank (1 bit), sampled with strobe, and output beam_on (1 bit, reset 0).
  - beam_on=1 during DRAW of unblanked lines, 0 otherwise.
  - Blanked move: SETUP loads x_out=tx, y_out=ty directly. DRAW then emits exactly one valid cycle (the target) with done=1 and beam_on=0.
- Not defined:
  - Ports blank and beam_on are absent.
  - All moves are stepped and drawn.

Test Plan:
- Reset: hold reset=0 for 2 cycles, release → ready=1, out_valid=0, done=0, x_out=0, y_out=0.
- Line (0,0)→(5,10): strobe x=5,y=10 → first valid cycle 2 clocks later at (0,0), then (1,1). 11 valid cycles total; y increments every step; x increments exactly 5 times; last point (5,10) with done=1; ready=1 the next cycle.
- Reverse line (5,10)→(1,2): 9 valid cycles, x and y monotonically decreasing, final (1,2) with done.
- Zero-length line: strobe (1,2) while at (1,2) → exactly one valid cycle (1,2) with done=1.
- Busy/reset:
  - Strobe (100,0) mid-draw → ignored; the line still ends at its original target.
  - reset=0 mid-draw → next cycle IDLE, ready=1, position (0,0), no done pulse.
- With LINE_STEPPER_BLANK_MOVE_EN: strobe (4000,4000) with blank=1 from (0,0) → single valid cycle at (4000,4000), beam_on=0, done=1. A following unblanked strobe (4000,3990) → beam_on=1 for 11 points.

Source files
------------

// File: rtl/line_stepper.sv
// line_stepper: responder on the strobe/ready point interface. It accepts a
// target endpoint and walks the beam from its current position to that target
// with integer Bresenham stepping. While drawing it emits one X/Y DAC pair per
// clock.
//
// Optional feature: define LINE_STEPPER_BLANK_MOVE_EN to add blanked moves.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-low reset
//   strobe     target handover; sampled only while ready=1
//   ready      idle, able to accept a target
//   x, y       target coordinates, sampled with strobe
//   blank      (feature only) move without drawing, sampled with strobe
//   beam_on    (feature only) high while drawing an unblanked line
//   x_out/y_out  current beam position
//   out_valid  x_out/y_out is a drawn point this cycle
//   done       one-cycle pulse on the final point
module line_stepper #(
   parameter int WIDTH  = 12,
   parameter int X_INIT = 0,
   parameter int Y_INIT = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             strobe,
   output logic             ready,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
`ifdef LINE_STEPPER_BLANK_MOVE_EN
   input  logic             blank,
   output logic             beam_on,
`endif
   output logic [WIDTH-1:0] x_out,
   output logic [WIDTH-1:0] y_out,
   output logic             out_valid,
   output logic             done
);

   // Two extra bits keep |delta| and err (range +-2^(WIDTH+1)) free of overflow.
   localparam int EW = WIDTH + 2;
   localparam logic [WIDTH-1:0] XI  = WIDTH'(X_INIT);
   localparam logic [WIDTH-1:0] YI  = WIDTH'(Y_INIT);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW} state_t;

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      tx_q, tx_d, ty_q, ty_d;
   logic [WIDTH-1:0]      x_q, x_d, y_q, y_d;
   logic signed [EW-1:0]  dx_q, dx_d, dy_q, dy_d, err_q, err_d;
   logic                  sx_q, sx_d, sy_q, sy_d;   // 1 = step up, 0 = step down
`ifdef LINE_STEPPER_BLANK_MOVE_EN
   logic                  blank_q, blank_d;
`endif

   logic                  at_tgt;
   logic signed [EW-1:0]  diff_x, diff_y;
   logic signed [EW:0]    e2, dx_e, dy_e;
   logic                  step_x, step_y;

   assign at_tgt = (x_q == tx_q) && (y_q == ty_q);
   assign diff_x = signed'({2'b00, tx_q}) - signed'({2'b00, x_q});
   assign diff_y = signed'({2'b00, ty_q}) - signed'({2'b00, y_q});

   // e2 = 2*err needs one more bit than err; compare against sign-extended deltas.
   assign e2     = {err_q, 1'b0};
   assign dx_e   = {dx_q[EW-1], dx_q};
   assign dy_e   = {dy_q[EW-1], dy_q};
   assign step_x = (e2 >= dy_e);
   assign step_y = (e2 <= dx_e);

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (strobe) state_d = S_SETUP;
         S_SETUP: state_d = S_DRAW;
         S_DRAW:  if (at_tgt) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      ready     = (state_q == S_IDLE);
      out_valid = (state_q == S_DRAW);
      done      = (state_q == S_DRAW) && at_tgt;
`ifdef LINE_STEPPER_BLANK_MOVE_EN
      beam_on   = (state_q == S_DRAW) && !blank_q;
`endif
   end

   assign x_out = x_q;
   assign y_out = y_q;

   // ---------------- datapath ----------------
   always_comb begin
      tx_d  = tx_q;
      ty_d  = ty_q;
      x_d   = x_q;
      y_d   = y_q;
      dx_d  = dx_q;
      dy_d  = dy_q;
      err_d = err_q;
      sx_d  = sx_q;
      sy_d  = sy_q;
`ifdef LINE_STEPPER_BLANK_MOVE_EN
      blank_d = blank_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (strobe) begin
               tx_d = x;
               ty_d = y;
`ifdef LINE_STEPPER_BLANK_MOVE_EN
               blank_d = blank;
`endif
            end
         end
         S_SETUP: begin
            dx_d  = diff_x[EW-1] ? -diff_x : diff_x;
            dy_d  = diff_y[EW-1] ? diff_y : -diff_y;   // dy is kept negative
            sx_d  = (tx_q > x_q);
            sy_d  = (ty_q > y_q);
            err_d = dx_d + dy_d;
`ifdef LINE_STEPPER_BLANK_MOVE_EN
            // Blanked move jumps straight to the target; DRAW then sees at_tgt.
            if (blank_q) begin
               x_d = tx_q;
               y_d = ty_q;
            end
`endif
         end
         S_DRAW: begin
            if (!at_tgt) begin
               // Both axes may step in the same cycle (diagonal move).
               if (step_x) begin
                  err_d = err_d + dy_q;
                  x_d   = sx_q ? x_q + ONE : x_q - ONE;
               end
               if (step_y) begin
                  err_d = err_d + dx_q;
                  y_d   = sy_q ? y_q + ONE : y_q - ONE;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_q  <= '0;
         ty_q  <= '0;
         x_q   <= XI;
         y_q   <= YI;
         dx_q  <= '0;
         dy_q  <= '0;
         err_q <= '0;
         sx_q  <= 1'b0;
         sy_q  <= 1'b0;
`ifdef LINE_STEPPER_BLANK_MOVE_EN
         blank_q <= 1'b0;
`endif
      end else begin
         tx_q  <= tx_d;
         ty_q  <= ty_d;
         x_q   <= x_d;
         y_q   <= y_d;
         dx_q  <= dx_d;
         dy_q  <= dy_d;
         err_q <= err_d;
         sx_q  <= sx_d;
         sy_q  <= sy_d;
`ifdef LINE_STEPPER_BLANK_MOVE_EN
         blank_q <= blank_d;
`endif
      end
   end

endmodule

// File: tb/tb_line_stepper.sv
// Self-checking bench for line_stepper. A cycle-level model built from the
// behavioural rules (point list per line, handshake phases) is compared with
// the DUT on every cycle; directed tests add literal expectations on top.
module tb_line_stepper;

   localparam int W = 12;

   logic         clk = 1'b0;
   logic         reset, strobe, ready, out_valid, done;
   logic [W-1:0] x, y, x_out, y_out;
`ifdef LINE_STEPPER_BLANK_MOVE_EN
   logic         blank, beam_on;
`endif

   line_stepper #(.WIDTH(W), .X_INIT(0), .Y_INIT(0)) dut (
      .clk(clk), .reset(reset), .strobe(strobe), .ready(ready),
      .x(x), .y(y),
`ifdef LINE_STEPPER_BLANK_MOVE_EN
      .blank(blank), .beam_on(beam_on),
`endif
      .x_out(x_out), .y_out(y_out), .out_valid(out_valid), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0, errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   int  m_ph = 0;          // 0 idle, 1 setup, 2 draw
   int  m_x = 0, m_y = 0, m_tx = 0, m_ty = 0;
   bit  m_blank = 0;
   int  mqx[$], mqy[$];    // points still to be emitted
   bit  started = 0;

   task automatic build_line(input int x0, input int y0, input int x1, input int y1);
      int dx, dy, sx, sy, err, e2, cx, cy;
      dx = (x1 > x0) ? x1 - x0 : x0 - x1;
      dy = (y1 > y0) ? y0 - y1 : y1 - y0;
      sx = (x1 > x0) ? 1 : -1;
      sy = (y1 > y0) ? 1 : -1;
      err = dx + dy;
      cx = x0; cy = y0;
      forever begin
         mqx.push_back(cx); mqy.push_back(cy);
         if (cx == x1 && cy == y1) break;
         e2 = 2 * err;
         if (e2 >= dy) begin err += dy; cx += sx; end
         if (e2 <= dx) begin err += dx; cy += sy; end
      end
   endtask

   always @(posedge clk) begin
      started = 1;
      if (!reset) begin
         m_ph = 0; m_x = 0; m_y = 0; m_blank = 0;
         mqx.delete(); mqy.delete();
      end else begin
         case (m_ph)
            0: if (strobe) begin
                  m_tx = int'(x); m_ty = int'(y); m_ph = 1;
`ifdef LINE_STEPPER_BLANK_MOVE_EN
                  m_blank = blank;
`endif
               end
            1: begin
                  if (m_blank) begin mqx.push_back(m_tx); mqy.push_back(m_ty); end
                  else build_line(m_x, m_y, m_tx, m_ty);
                  m_ph = 2;
               end
            default: begin
                  void'(mqx.pop_front()); void'(mqy.pop_front());
                  if (mqx.size() == 0) begin m_ph = 0; m_x = m_tx; m_y = m_ty; end
               end
         endcase
      end
   end

   // ---------------- per-cycle compare + DUT capture ----------------
   int dqx[$], dqy[$];
   int dn = 0, bon = 0;

   always @(negedge clk) begin
      bit ev;
      if (started) begin
         ev = (m_ph == 2);
         chk("ready", int'(ready), int'(m_ph == 0));
         chk("out_valid", int'(out_valid), int'(ev));
         chk("done", int'(done), int'(ev && mqx.size() == 1));
         chk("x_out", int'(x_out), ev ? mqx[0] : m_x);
         chk("y_out", int'(y_out), ev ? mqy[0] : m_y);
`ifdef LINE_STEPPER_BLANK_MOVE_EN
         chk("beam_on", int'(beam_on), int'(ev && !m_blank));
         if (beam_on) bon++;
`endif
         if (out_valid) begin dqx.push_back(int'(x_out)); dqy.push_back(int'(y_out)); end
         if (done) dn++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic clear_log();
      dqx.delete(); dqy.delete(); dn = 0; bon = 0;
   endtask

   task automatic send(input int tx, input int ty, input bit b);
      strobe = 1'b1; x = W'(tx); y = W'(ty);
`ifdef LINE_STEPPER_BLANK_MOVE_EN
      blank = b;
`else
      if (b) $display("note: blank request ignored in this build");
`endif
      step();
      strobe = 1'b0;
   endtask

   task automatic wait_ready(input int maxc);
      int i;
      for (i = 0; i < maxc; i++) begin
         if (ready) break;
         step();
      end
      chk("wait_ready_timeout", int'(ready), 1);
   endtask

   task automatic chk_pt(input string name, input int idx, input int ex, input int ey);
      if (idx < dqx.size()) begin
         chk({name, "_x"}, dqx[idx], ex);
         chk({name, "_y"}, dqy[idx], ey);
      end
   endtask

   initial begin
      int inc_x, inc_y, bad;
      reset = 1'b0; strobe = 1'b0; x = '0; y = '0;
`ifdef LINE_STEPPER_BLANK_MOVE_EN
      blank = 1'b0;
`endif
      step(); step();
      reset = 1'b1;
      step();
      chk("rst_ready", int'(ready), 1);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_x", int'(x_out), 0);
      chk("rst_y", int'(y_out), 0);

      // (0,0) -> (5,10)
      clear_log();
      send(5, 10, 0);
      chk("lat_setup_valid", int'(out_valid), 0);
      step();
      chk("lat_first_valid", int'(out_valid), 1);
      wait_ready(60);
      chk("l1_count", dqx.size(), 11);
      chk("l1_dones", dn, 1);
      chk_pt("l1_p0", 0, 0, 0);
      chk_pt("l1_p1", 1, 1, 1);
      chk_pt("l1_last", 10, 5, 10);
      inc_x = 0; inc_y = 0;
      for (int i = 1; i < dqx.size(); i++) begin
         if (dqx[i] == dqx[i-1] + 1) inc_x++;
         if (dqy[i] == dqy[i-1] + 1) inc_y++;
      end
      chk("l1_x_incs", inc_x, 5);
      chk("l1_y_incs", inc_y, 10);

      // (5,10) -> (1,2)
      clear_log();
      send(1, 2, 0);
      wait_ready(60);
      chk("l2_count", dqx.size(), 9);
      chk_pt("l2_last", 8, 1, 2);
      bad = 0;
      for (int i = 1; i < dqx.size(); i++)
         if (dqx[i] > dqx[i-1] || dqy[i] > dqy[i-1]) bad++;
      chk("l2_monotonic", bad, 0);

      // zero-length line at (1,2)
      clear_log();
      send(1, 2, 0);
      wait_ready(20);
      chk("l3_count", dqx.size(), 1);
      chk("l3_dones", dn, 1);
      chk_pt("l3_p0", 0, 1, 2);

      // strobe while busy is ignored: (1,2) -> (20,12)
      clear_log();
      send(20, 12, 0);
      step(); step(); step();
      send(100, 0, 0);
      wait_ready(100);
      chk("l4_count", dqx.size(), 20);
      chk_pt("l4_last", 19, 20, 12);
      chk("l4_dones", dn, 1);
      step(); step();
      chk("l4_still_idle_x", int'(x_out), 20);

      // reset mid-draw: (20,12) -> (40,30)
      clear_log();
      send(40, 30, 0);
      step(); step(); step();
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("midrst_ready", int'(ready), 1);
      chk("midrst_valid", int'(out_valid), 0);
      chk("midrst_x", int'(x_out), 0);
      chk("midrst_y", int'(y_out), 0);
      step(); step();
      chk("midrst_dones", dn, 0);

`ifdef LINE_STEPPER_BLANK_MOVE_EN
      // blanked jump (0,0) -> (4000,4000), then drawn (4000,4000) -> (4000,3990)
      clear_log();
      send(4000, 4000, 1);
      wait_ready(20);
      chk("blk_count", dqx.size(), 1);
      chk_pt("blk_p0", 0, 4000, 4000);
      chk("blk_beam", bon, 0);
      chk("blk_dones", dn, 1);
      clear_log();
      send(4000, 3990, 0);
      wait_ready(40);
      chk("unblk_count", dqx.size(), 11);
      chk("unblk_beam", bon, 11);
      chk_pt("unblk_last", 10, 4000, 3990);
`endif

      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete, expected finish");
      $fatal(1);
   end

endmodule
